// File: rtl/branch_resolve_queue_if.sv
// Fetch/execute-side handshake and predictor-training bus for branch_resolve_queue.
// The master drives pushes and resolves. The slave (the queue) returns training, flush and statistics.
`timescale 1ns/1ps

interface branch_resolve_queue_if #(
  parameter int IDX_W = 12,
  parameter int PC_W  = 32
);
  logic             push_valid;
  logic [IDX_W-1:0] push_idx;
  logic             push_pred;
  logic [PC_W-1:0]  push_pc;
  logic [PC_W-1:0]  push_tgt;
  logic             push_ready;

  logic             res_valid;
  logic             res_taken;

  logic             upd_valid;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_taken;
  logic             flush;
  logic [PC_W-1:0]  redirect_pc;
  logic             res_err;
  logic [15:0]      stat_total;
  logic [15:0]      stat_miss;

  modport master (
    output push_valid, push_idx, push_pred, push_pc, push_tgt,
    output res_valid, res_taken,
    input  push_ready,
    input  upd_valid, upd_idx, upd_taken, flush, redirect_pc, res_err,
    input  stat_total, stat_miss
  );

  modport slave (
    input  push_valid, push_idx, push_pred, push_pc, push_tgt,
    input  res_valid, res_taken,
    output push_ready,
    output upd_valid, upd_idx, upd_taken, flush, redirect_pc, res_err,
    output stat_total, stat_miss
  );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-flight conditional-branch queue. Each in-order resolve pops the head and emits predictor training.
// On a mispredict it also emits a redirect flush and squashes every younger entry.
`timescale 1ns/1ps

module branch_resolve_queue #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 12,
  parameter int PC_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  branch_resolve_queue_if.slave bus
);
  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  typedef logic [PTR_W-1:0] ptr_t;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             pred;
    logic [PC_W-1:0]  pc;
    logic [PC_W-1:0]  tgt;
  } entry_t;

  entry_t mem [DEPTH];

  ptr_t   wr_ptr, rd_ptr, count;
  entry_t head;
  entry_t push_entry;
  logic   can_push;
  logic   do_push, do_res, empty_res, mispredict;
  logic [PC_W-1:0] fix_pc;

  logic             upd_valid_q;
  logic [IDX_W-1:0] upd_idx_q;
  logic             upd_taken_q;
  logic             flush_q;
  logic [PC_W-1:0]  redirect_pc_q;
  logic             res_err_q;
  logic [15:0]      stat_total_q;
  logic [15:0]      stat_miss_q;

  // Ready reflects occupancy at the start of the cycle. A same-cycle pop does not free a slot.
  assign can_push = (count < ptr_t'(DEPTH));

  always_comb begin
    // NOTE: every signal below is assigned on every path through this block, so no latch is inferred.
    head       = mem[rd_ptr[AW-1:0]];
    push_entry = '{idx: bus.push_idx, pred: bus.push_pred, pc: bus.push_pc, tgt: bus.push_tgt};
    do_res     = bus.res_valid && (count != '0);
    empty_res  = bus.res_valid && (count == '0);
    mispredict = do_res && (bus.res_taken != head.pred);
    // A push that coincides with a mispredict is wrong-path and is dropped.
    do_push    = bus.push_valid && can_push && !mispredict;
    fix_pc     = bus.res_taken ? head.tgt : head.pc + PC_W'(4);
  end

  // NOTE: the entry storage has no reset. Count and pointers alone decide which slots are live.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_entry;
    end
  end

  // Pointers carry one spare bit. Only the low AW bits address storage, so slots wrap modulo DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (mispredict) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ptr_t'(1);
      if (do_res)  rd_ptr <= rd_ptr + ptr_t'(1);
      unique case ({do_push, do_res})
        2'b10:   count <= count + ptr_t'(1);
        2'b01:   count <= count - ptr_t'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upd_valid_q   <= 1'b0;
      upd_idx_q     <= '0;
      upd_taken_q   <= 1'b0;
      flush_q       <= 1'b0;
      redirect_pc_q <= '0;
      res_err_q     <= 1'b0;
      stat_total_q  <= '0;
      stat_miss_q   <= '0;
    end else begin
      upd_valid_q <= do_res;
      flush_q     <= mispredict;
      res_err_q   <= empty_res;
      if (do_res) begin
        upd_idx_q    <= head.idx;
        upd_taken_q  <= bus.res_taken;
        stat_total_q <= stat_total_q + 16'd1;
      end
      if (mispredict) begin
        redirect_pc_q <= fix_pc;
        stat_miss_q   <= stat_miss_q + 16'd1;
      end
    end
  end

  assign bus.push_ready  = can_push;
  assign bus.upd_valid   = upd_valid_q;
  assign bus.upd_idx     = upd_idx_q;
  assign bus.upd_taken   = upd_taken_q;
  assign bus.flush       = flush_q;
  assign bus.redirect_pc = redirect_pc_q;
  assign bus.res_err     = res_err_q;
  assign bus.stat_total  = stat_total_q;
  assign bus.stat_miss   = stat_miss_q;

  // Structural invariants: occupancy bounded, a flush always accompanies a training update.
  a_count_bound: assert property (@(posedge clk) disable iff (rst) count <= ptr_t'(DEPTH));
  a_flush_upd:   assert property (@(posedge clk) disable iff (rst) flush_q |-> upd_valid_q);
  a_err_excl:    assert property (@(posedge clk) disable iff (rst) !(res_err_q && upd_valid_q));

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Self-checking bench for branch_resolve_queue: directed vector table, hand sequences for wrap and async reset,
// and randomized traffic checked against a queue-based reference model.
`timescale 1ns/1ps

module tb_branch_resolve_queue;
  localparam int DEPTH = 4;
  localparam int IDX_W = 12;
  localparam int PC_W  = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  branch_resolve_queue_if #(.IDX_W(IDX_W), .PC_W(PC_W)) bus ();

  branch_resolve_queue #(.DEPTH(DEPTH), .IDX_W(IDX_W), .PC_W(PC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [IDX_W-1:0] idx;
    logic             pred;
    logic [PC_W-1:0]  pc;
    logic [PC_W-1:0]  tgt;
  } ent_t;

  ent_t             mq[$];
  logic [IDX_W-1:0] m_idx;
  logic             m_taken;
  logic [PC_W-1:0]  m_redir;
  logic [15:0]      m_total, m_miss;

  task automatic model_reset();
    mq.delete();
    m_idx   = '0;
    m_taken = 1'b0;
    m_redir = '0;
    m_total = '0;
    m_miss  = '0;
  endtask

  task automatic drive(input logic pv, input logic [IDX_W-1:0] idx, input logic pred,
                       input logic [PC_W-1:0] pc, input logic [PC_W-1:0] tgt,
                       input logic rv, input logic rt);
    bus.push_valid = pv;
    bus.push_idx   = idx;
    bus.push_pred  = pred;
    bus.push_pc    = pc;
    bus.push_tgt   = tgt;
    bus.res_valid  = rv;
    bus.res_taken  = rt;
  endtask

  // One clock of traffic: drive, check ready, predict with the model, clock, check registered outputs.
  task automatic step(input logic pv, input logic [IDX_W-1:0] idx, input logic pred,
                      input logic [PC_W-1:0] pc, input logic [PC_W-1:0] tgt,
                      input logic rv, input logic rt);
    logic e_ready, e_upd, e_flush, e_err, mis;
    ent_t h;
    drive(pv, idx, pred, pc, tgt, rv, rt);
    #1;
    e_ready = (mq.size() < DEPTH);
    check("step push_ready", 32'(bus.push_ready), 32'(e_ready));
    e_upd = 1'b0; e_flush = 1'b0; e_err = 1'b0; mis = 1'b0;
    if (rv) begin
      if (mq.size() == 0) begin
        e_err = 1'b1;
      end else begin
        h       = mq.pop_front();
        e_upd   = 1'b1;
        m_idx   = h.idx;
        m_taken = rt;
        m_total = m_total + 16'd1;
        if (rt != h.pred) begin
          mis     = 1'b1;
          e_flush = 1'b1;
          m_miss  = m_miss + 16'd1;
          m_redir = rt ? h.tgt : h.pc + 32'd4;
          mq.delete();
        end
      end
    end
    if (pv && e_ready && !mis) mq.push_back('{idx: idx, pred: pred, pc: pc, tgt: tgt});
    @(posedge clk);
    #1;
    check("step upd_valid",   32'(bus.upd_valid),   32'(e_upd));
    check("step upd_idx",     32'(bus.upd_idx),     32'(m_idx));
    check("step upd_taken",   32'(bus.upd_taken),   32'(m_taken));
    check("step flush",       32'(bus.flush),       32'(e_flush));
    check("step redirect_pc", bus.redirect_pc,      m_redir);
    check("step res_err",     32'(bus.res_err),     32'(e_err));
    check("step stat_total",  32'(bus.stat_total),  32'(m_total));
    check("step stat_miss",   32'(bus.stat_miss),   32'(m_miss));
  endtask

  task automatic check_cleared(input string tag);
    check({tag, " push_ready"},  32'(bus.push_ready), 32'd1);
    check({tag, " upd_valid"},   32'(bus.upd_valid),  32'd0);
    check({tag, " upd_idx"},     32'(bus.upd_idx),    32'd0);
    check({tag, " upd_taken"},   32'(bus.upd_taken),  32'd0);
    check({tag, " flush"},       32'(bus.flush),      32'd0);
    check({tag, " redirect_pc"}, bus.redirect_pc,     32'd0);
    check({tag, " res_err"},     32'(bus.res_err),    32'd0);
    check({tag, " stat_total"},  32'(bus.stat_total), 32'd0);
    check({tag, " stat_miss"},   32'(bus.stat_miss),  32'd0);
  endtask

  task automatic do_reset();
    drive(0, '0, 0, '0, '0, 0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_cleared("reset");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic             pv;
    logic [IDX_W-1:0] idx;
    logic             pred;
    logic [PC_W-1:0]  pc, tgt;
    logic             rv, rt;
    logic             e_ready;
    logic             e_upd;
    logic [IDX_W-1:0] e_idx;
    logic             e_taken;
    logic             e_flush;
    logic [PC_W-1:0]  e_redir;
    logic             e_err;
    logic [15:0]      e_total, e_miss;
  } vec_t;

  function automatic vec_t mk(input logic pv, input logic [11:0] idx, input logic pred,
                              input logic [31:0] pc, input logic [31:0] tgt,
                              input logic rv, input logic rt,
                              input logic e_ready, input logic e_upd, input logic [11:0] e_idx,
                              input logic e_taken, input logic e_flush, input logic [31:0] e_redir,
                              input logic e_err, input logic [15:0] e_total, input logic [15:0] e_miss);
    vec_t v;
    v.pv = pv; v.idx = idx; v.pred = pred; v.pc = pc; v.tgt = tgt; v.rv = rv; v.rt = rt;
    v.e_ready = e_ready; v.e_upd = e_upd; v.e_idx = e_idx; v.e_taken = e_taken;
    v.e_flush = e_flush; v.e_redir = e_redir; v.e_err = e_err; v.e_total = e_total; v.e_miss = e_miss;
    return v;
  endfunction

  vec_t vecs[15];

  initial begin
    // pv idx pred pc tgt rv rt | ready upd idx taken flush redirect err total miss
    vecs[0]  = mk(1, 12'h0A5, 1, 32'h100, 32'h140, 0, 0,  1, 0, 12'h000, 0, 0, 32'h000, 0, 0, 0);
    vecs[1]  = mk(0, 12'h000, 0, 32'h000, 32'h000, 1, 1,  1, 1, 12'h0A5, 1, 0, 32'h000, 0, 1, 0);
    vecs[2]  = mk(1, 12'h010, 1, 32'h200, 32'h260, 0, 0,  1, 0, 12'h0A5, 1, 0, 32'h000, 0, 1, 0);
    vecs[3]  = mk(0, 12'h000, 0, 32'h000, 32'h000, 1, 0,  1, 1, 12'h010, 0, 1, 32'h204, 0, 2, 1);
    vecs[4]  = mk(1, 12'h001, 1, 32'h400, 32'h480, 0, 0,  1, 0, 12'h010, 0, 0, 32'h204, 0, 2, 1);
    vecs[5]  = mk(1, 12'h002, 0, 32'h404, 32'h4C0, 0, 0,  1, 0, 12'h010, 0, 0, 32'h204, 0, 2, 1);
    vecs[6]  = mk(1, 12'h003, 1, 32'h408, 32'h500, 0, 0,  1, 0, 12'h010, 0, 0, 32'h204, 0, 2, 1);
    vecs[7]  = mk(1, 12'h004, 1, 32'h40C, 32'h540, 0, 0,  1, 0, 12'h010, 0, 0, 32'h204, 0, 2, 1);
    // full: push refused, head resolves correctly
    vecs[8]  = mk(1, 12'h005, 1, 32'h410, 32'h580, 1, 1,  0, 1, 12'h001, 1, 0, 32'h204, 0, 3, 1);
    vecs[9]  = mk(0, 12'h000, 0, 32'h000, 32'h000, 0, 0,  1, 0, 12'h001, 1, 0, 32'h204, 0, 3, 1);
    // mispredict head (pred 0, taken 1) with a simultaneous push that must be dropped
    vecs[10] = mk(1, 12'h006, 1, 32'h414, 32'h5C0, 1, 1,  1, 1, 12'h002, 1, 1, 32'h4C0, 0, 4, 2);
    vecs[11] = mk(0, 12'h000, 0, 32'h000, 32'h000, 1, 1,  1, 0, 12'h002, 1, 0, 32'h4C0, 1, 4, 2);
    // empty resolve with same-cycle push: error, push still accepted
    vecs[12] = mk(1, 12'h007, 0, 32'h300, 32'h380, 1, 0,  1, 0, 12'h002, 1, 0, 32'h4C0, 1, 4, 2);
    vecs[13] = mk(0, 12'h000, 0, 32'h000, 32'h000, 1, 1,  1, 1, 12'h007, 1, 1, 32'h380, 0, 5, 3);
    vecs[14] = mk(0, 12'h000, 0, 32'h000, 32'h000, 0, 0,  1, 0, 12'h007, 1, 0, 32'h380, 0, 5, 3);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [IDX_W-1:0] r_idx;
    logic [PC_W-1:0]  r_pc, r_tgt;
    logic             r_pv, r_rv, r_rt, r_pred;

    drive(0, '0, 0, '0, '0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_cleared("init");
    @(negedge clk);
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].pv, vecs[i].idx, vecs[i].pred, vecs[i].pc, vecs[i].tgt, vecs[i].rv, vecs[i].rt);
      #1;
      check($sformatf("vec%0d push_ready", i), 32'(bus.push_ready), 32'(vecs[i].e_ready));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d upd_valid", i),   32'(bus.upd_valid),  32'(vecs[i].e_upd));
      check($sformatf("vec%0d upd_idx", i),     32'(bus.upd_idx),    32'(vecs[i].e_idx));
      check($sformatf("vec%0d upd_taken", i),   32'(bus.upd_taken),  32'(vecs[i].e_taken));
      check($sformatf("vec%0d flush", i),       32'(bus.flush),      32'(vecs[i].e_flush));
      check($sformatf("vec%0d redirect_pc", i), bus.redirect_pc,     vecs[i].e_redir);
      check($sformatf("vec%0d res_err", i),     32'(bus.res_err),    32'(vecs[i].e_err));
      check($sformatf("vec%0d stat_total", i),  32'(bus.stat_total), 32'(vecs[i].e_total));
      check($sformatf("vec%0d stat_miss", i),   32'(bus.stat_miss),  32'(vecs[i].e_miss));
    end

    // Pointer wrap: push i while resolving i-1 correctly, ten branches in total
    do_reset();
    for (int i = 0; i <= 10; i++) begin
      step(i < 10, 12'(12'h100 + i), (i % 3) != 0, 32'(32'h1000 + 4 * i), 32'(32'h2000 + 16 * i),
           i > 0, ((i - 1) % 3) != 0);
    end
    check("wrap stat_total", 32'(bus.stat_total), 32'd10);
    check("wrap stat_miss",  32'(bus.stat_miss),  32'd0);

    // Asynchronous reset mid-stream with two entries held
    step(1, 12'h0AA, 1, 32'h500, 32'h600, 0, 0);
    step(1, 12'h0BB, 1, 32'h504, 32'h640, 0, 0);
    step(1, 12'h0CC, 0, 32'h508, 32'h680, 1, 1);
    #2;
    rst = 1'b1;
    #1;
    check_cleared("async");
    #2;
    rst = 1'b0;
    model_reset();
    step(0, '0, 0, '0, '0, 1, 1);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      r_pv   = ($urandom_range(0, 9) < 7);
      r_rv   = ($urandom_range(0, 9) < 5);
      r_pred = 1'($urandom_range(0, 1));
      r_idx  = IDX_W'($urandom());
      r_pc   = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
      r_tgt  = $urandom();
      if (mq.size() > 0 && $urandom_range(0, 9) < 8) r_rt = mq[0].pred;
      else                                            r_rt = 1'($urandom_range(0, 1));
      step(r_pv, r_idx, r_pred, r_pc, r_tgt, r_rv, r_rt);
    end

    drive(0, '0, 0, '0, '0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- Consumer end of the branch-prediction interface.
- Fetch pushes each conditional branch it predicted, tagged with the pattern-table index it used. Execute later reports the actual outcome, in program order.
- For each resolved branch, the block produces the training update for the predictor (index plus actual taken) and, on a misprediction, a registered flush with the correct redirect PC.
- Keeps in-flight prediction state in a small FIFO.

Parameters:
- DEPTH, 4, number of in-flight branch entries; power of 2, minimum 2.
- IDX_W, 12, predictor table index width.
- PC_W, 32, program-counter width.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- push_valid  in  1  fetch issues a predicted conditional branch this cycle.
- push_idx  in  IDX_W  predictor index used for the prediction.
- push_pred  in  1  predicted direction; 1 = taken.
- push_pc  in  PC_W  branch instruction PC.
- push_tgt  in  PC_W  branch taken-target PC.
- push_ready  out  1  entry available; a push is accepted only when push_valid and push_ready are both 1.
- res_valid  in  1  execute resolves the oldest in-flight branch.
- res_taken  in  1  actual outcome; 1 = taken.
- upd_valid  out  1  one-cycle pulse: predictor training request.
- upd_idx  out  IDX_W  index to train.
- upd_taken  out  1  actual outcome to train with.
- flush  out  1  one-cycle pulse: mispredict, squash younger work.
- redirect_pc  out  PC_W  correct next PC; valid while flush = 1.
- res_err  out  1  one-cycle pulse: res_valid arrived with the queue empty.
- stat_total  out  16  count of resolved branches; wraps at 2^16.
- stat_miss  out  16  count of mispredicts; wraps at 2^16.

Behaviour:
- Storage
  - Circular FIFO with DEPTH entries; each entry holds {idx, pred, pc, tgt}.
  - Write pointer, read pointer and count are each log2(DEPTH)+1 bits wide (count ranges 0..DEPTH).
  - Pointers wrap modulo DEPTH.
- Reset (asynchronous, any time, including mid-operation)
  - count = 0, pointers = 0.
  - upd_valid, flush and res_err = 0.
  - upd_idx = 0, upd_taken = 0, redirect_pc = 0.
  - stat_total = 0, stat_miss = 0.
  - After reset, push_ready = 1.
- push_ready
  - Combinational: push_ready = (count < DEPTH).
  - A pop in the same cycle does not free a slot for that cycle's push.
- Resolve (res_valid = 1, count > 0)
  - Pop the head entry.
  - Next cycle, registered: upd_valid = 1, upd_idx = head.idx, upd_taken = res_taken.
  - stat_total increments by 1.
  - If res_taken != head.pred, the branch was mispredicted:
    - flush = 1 next cycle, and stat_miss increments by 1.
    - redirect_pc = head.tgt if res_taken = 1, else head.pc + 4 (modulo 2^PC_W).
    - The entire queue is cleared (count = 0, read pointer = write pointer), because all younger entries are wrong-path.
- Resolve with an empty queue (res_valid = 1, count = 0)
  - Nothing is popped; no update and no counter change.
  - res_err = 1 next cycle.
  - A push in the same cycle does not satisfy the resolve.
- Simultaneous push and correct-prediction resolve
  - Both take effect; count is unchanged.
- Simultaneous push and mispredict resolve
  - The push is dropped: it is wrong-path, and the queue ends empty.
- Output pulses
  - upd_valid, flush and res_err are held for exactly one cycle, then return to 0.
  - upd_idx, upd_taken and redirect_pc hold their last values between pulses.
- Latency
  - Resolve-to-update and resolve-to-flush: 1 cycle.
  - Push-to-resolvable: a branch pushed in cycle N can be resolved from cycle N+1.
- Behaviour is undefined for X/Z on res_valid or push_valid; the bench drives only 0/1.

Test Plan:
- Reset, then push idx=0x0A5 pred=1 pc=0x100 tgt=0x140; next cycle resolve taken=1 -> upd_valid=1, upd_idx=0x0A5, upd_taken=1, flush=0, stat_total=1, stat_miss=0.
- Push idx=0x010 pred=1 pc=0x200 tgt=0x260, then resolve taken=0 -> flush=1, redirect_pc=0x204, upd_taken=0, stat_miss=1.
- Push 4 entries back to back (DEPTH=4) -> push_ready=0 after the 4th. Push attempt while full plus a correct resolve in the same cycle -> push not accepted, count=3, push_ready=1 next cycle.
- Fill 3 entries, then mispredict the head while push_valid=1 -> flush=1, queue empty, dropped push never appears. A following res_valid gives res_err=1 and no upd_valid.
- Push pred=0 pc=0x300 tgt=0x380, then resolve taken=1 -> redirect_pc=0x380. Wrap test: 10 push/resolve pairs with correct predictions -> FIFO order preserved across pointer wrap, stat_total=10.
- Assert rst asynchronously mid-stream with 2 entries held -> outputs clear immediately without a clock edge, push_ready=1, stat counters=0, and the next resolve gives res_err=1.
